instruction_fetcher: RTL
========================

INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, instruction-queue depth (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous active-high reset.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes the block.
REQ-006 SHALL have port inst_valid  output  1  fetch request to the cache.
REQ-007 SHALL have port PC  output  32  fetch address to the cache.
REQ-008 SHALL have port inst_ready  input  1  cache response strobe (may be combinational, same cycle as inst_valid on a hit).
REQ-009 SHALL have port inst_res  input  32  instruction word, valid while inst_ready is high.
REQ-010 SHALL have port flush  input  1  one-cycle redirect request.
REQ-011 SHALL have port flush_pc  input  32  redirect target, sampled when flush is high.
REQ-012 SHALL have port out_valid  output  1  queue non-empty.
REQ-013 SHALL have port out_inst  output  32  instruction at queue head.
REQ-014 SHALL have port out_pc  output  32  address of the head instruction.
REQ-015 SHALL have port out_ready  input  1  consumer pops the head when out_valid and out_ready are both high.

Function
REQ-016 SHALL implement a circular queue of QDEPTH {inst, pc} entries with head, tail and count registers; count SHALL range 0..QDEPTH and pointers SHALL wrap modulo QDEPTH.
REQ-017 SHALL drive out_valid = (count != 0) and out_inst/out_pc from the head entry, directly from registers.
REQ-018 SHALL implement states FETCH (normal) and DISCARD (flush pending while a request is outstanding).
REQ-019 In FETCH, SHALL assert inst_valid when count < QDEPTH, and SHALL deassert it when count = QDEPTH (stall).
REQ-020 In DISCARD, SHALL assert inst_valid regardless of count.
REQ-021 While inst_valid is high and inst_ready is low, SHALL hold PC stable, because the cache samples PC combinationally throughout a miss.
REQ-022 In FETCH, when inst_ready is high and flush is low, SHALL push {inst_res, PC} at tail and set PC <= PC + 4 (32-bit wrap).
REQ-023 On a simultaneous push and pop, SHALL leave count unchanged and advance both pointers; pushing at count = QDEPTH SHALL NOT occur, by REQ-019.
REQ-024 On flush, SHALL clear the queue (count, head and tail set to 0); out_valid SHALL be low in the next cycle, and any same-cycle pop SHALL be ignored.
REQ-025 If flush occurs in FETCH with inst_valid high and inst_ready low, SHALL latch flush_pc into pending_pc and enter DISCARD, keeping PC unchanged.
REQ-026 Otherwise, on flush, SHALL set PC <= flush_pc, stay in or return to FETCH, and drop any same-cycle inst_res.
REQ-027 In DISCARD, SHALL drop the response on inst_ready, then set PC <= pending_pc and enter FETCH.
REQ-028 A further flush while in DISCARD SHALL overwrite pending_pc (the last redirect wins); if it coincides with inst_ready, flush_pc SHALL take priority over pending_pc.
REQ-029 While rdy_in is low, SHALL update no register, perform no push or pop, and hold all outputs.

Reset
REQ-030 On rst_in high at a clock edge, SHALL set PC = RESET_PC, state = FETCH, count = head = tail = 0, pending_pc = 0.
REQ-031 During and after reset, out_valid SHALL be 0; inst_valid SHALL be 1 in the first cycle after rst_in deasserts.
REQ-032 Reset mid-transaction SHALL abandon all queued and in-flight instructions, with no pending redirect retained; reset SHALL override flush and rdy_in.

Verification
REQ-033 Scenario: reset, then the cache hits each cycle with inst_res = 32'h00000013 and out_ready = 1 -> out_pc sequence 0x0, 0x4, 0x8, ..., with one entry per cycle.
REQ-034 Scenario: out_ready = 0 with all hits -> after 4 pushes count = 4 and inst_valid = 0, PC = 0x10 and held; a single pop re-enables fetching of 0x10.
REQ-035 Scenario: miss in progress at PC = 0x8 (inst_ready low for 5 cycles), flush with flush_pc = 0x100 in cycle 2 -> PC stays 0x8 until inst_ready; that word is not enqueued; the next request is at PC = 0x100.
REQ-036 Scenario: flush with flush_pc = 0x40 in the same cycle as an inst_ready hit at 0x20 and a pop -> queue empty next cycle, 0x20 not enqueued, PC = 0x40.
REQ-037 Scenario: rdy_in low for 3 cycles with out_ready high and a hit presented -> count, PC, head and tail are unchanged over those cycles; normal flow resumes when rdy_in returns high.
REQ-038 Scenario: two flushes (0x200, then 0x300) during one outstanding miss -> exactly one request, to PC = 0x300, follows the discarded response.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// instruction_fetcher_if: cache request/response, redirect and instruction-queue output signals.
interface instruction_fetcher_if;
    logic        inst_valid, inst_ready, flush, out_valid, out_ready;
    logic [31:0] PC, inst_res, flush_pc, out_inst, out_pc;
    modport master(output inst_valid, PC, out_valid, out_inst, out_pc,
                   input inst_ready, inst_res, flush, flush_pc, out_ready);
    modport slave(input inst_valid, PC, out_valid, out_inst, out_pc,
                  output inst_ready, inst_res, flush, flush_pc, out_ready);
endinterface

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: sequential fetch into a circular queue, with redirects that wait out an outstanding miss.
module instruction_fetcher #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    instruction_fetcher_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
    typedef enum logic {FETCH, DISCARD} state_t;
    state_t        state;
    logic [31:0]   pc, pending_pc;
    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc [QDEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          fetch_req, push, pop;
    assign fetch_req      = state == DISCARD || count != FULL;
    assign push           = state == FETCH && fetch_req && bus.inst_ready && !bus.flush;
    assign pop            = count != '0 && bus.out_ready && !bus.flush;
    assign bus.inst_valid = fetch_req;
    assign bus.PC         = pc;
    assign bus.out_valid  = count != '0;
    assign bus.out_inst   = q_inst[head];
    assign bus.out_pc     = q_pc[head];
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= '0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
        end else if (rdy_in) begin
            if (bus.flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
                // A miss still in flight must complete at the old PC before redirecting.
                if (fetch_req && !bus.inst_ready) begin
                    pending_pc <= bus.flush_pc;
                    state      <= DISCARD;
                end else begin
                    pc    <= bus.flush_pc;
                    state <= FETCH;
                end
            end else begin
                if (push) begin
                    q_inst[tail] <= bus.inst_res;
                    q_pc[tail]   <= pc;
                    tail         <= tail + 1'b1;
                    pc           <= pc + 32'd4;
                end
                if (pop) head <= head + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
                if (state == DISCARD && bus.inst_ready) begin
                    pc    <= pending_pc;
                    state <= FETCH;
                end
            end
        end
    end
endmodule
